// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and default sizes for the posted-write store buffer.
//   SB_DEPTH / SB_AW / SB_DW : default entry count, address width, data width
//   SB_PTR_W                 : head/tail pointer width for the default depth
//   sb_entry_t               : one pending store {addr, data} at the default widths
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: youngest-first address comparator over the pending stores.
//   entry_addr/entry_data : circular-buffer storage (slot-indexed)
//   head, count           : oldest slot and number of valid entries
//   cpu_addr              : load address to look up
//   hit                   : some valid entry matches cpu_addr
//   hit_data              : data of the youngest matching entry ('0 on miss)
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic [AW-1:0]            entry_addr [DEPTH],
  input  logic [DW-1:0]            entry_data [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            cpu_addr,
  output logic                     hit,
  output logic [DW-1:0]            hit_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (((PW+1)'(k) < count) && (entry_addr[idx] == cpu_addr)) begin
        hit      = 1'b1;
        hit_data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between EX/MEM and a single-port data memory.
// Stores are accepted in one cycle and drained in FIFO order on cycles the CPU
// leaves the memory port idle (or when full / flushing / hazarding). Loads go
// to memory combinationally.
//   clk, reset (async, active-low)
//   cpu_read, cpu_write, cpu_addr, cpu_wdata : CPU request
//   cpu_rdata, stall                          : load result, request-not-accepted
//   flush, empty                              : force draining, no pending stores
//   mem_addr, mem_wdata, mem_read, mem_write, mem_rdata : data memory port
// Build option: define STORE_BUF_FWD_EN to forward load data from pending
// stores; otherwise a load that hits a pending store stalls until it drains.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  input  logic          flush,
  output logic          empty,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

`ifdef STORE_BUF_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic          full;
  logic          load_req;
  logic          hit;
  logic          hazard;
  logic          drain;
  logic          enq;
  logic [DW-1:0] hit_data;

  // The comparator is always present: without forwarding its hit drives the
  // load-after-store hazard stall.
  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd_match (
    .entry_addr (addr_q),
    .entry_data (data_q),
    .head       (head_q),
    .count      (count_q),
    .cpu_addr   (cpu_addr),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  always_comb begin
    full     = (count_q == FULL_CNT);
    // Read+write together is treated as a plain store.
    load_req = cpu_read & ~cpu_write;
    hazard   = load_req & hit & ~FWD_EN;
    drain    = (count_q != '0) & (full | flush | (~cpu_read & ~cpu_write) | hazard);
    // A full buffer drains its head in the same cycle, so stores never stall.
    enq      = cpu_write;

    stall     = load_req & drain;
    mem_write = drain;
    mem_read  = load_req & ~drain;
    mem_addr  = mem_read ? cpu_addr : addr_q[head_q];
    mem_wdata = data_q[head_q];
    cpu_rdata = (FWD_EN & hit) ? hit_data : mem_rdata;
    empty     = (count_q == '0);

    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (enq) begin
      addr_d[tail_q] = cpu_addr;
      data_d[tail_q] = cpu_wdata;
      tail_d         = tail_q + 1'b1;
    end
    if (drain) begin
      head_d = head_q + 1'b1;
    end
    case ({enq, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: self-checking bench for store_buffer. A queue of pending
// stores plus a reference memory image predict every port value each cycle.
// Works with or without STORE_BUF_FWD_EN defined.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = SB_DEPTH;
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write, flush;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, empty, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .flush     (flush),
    .empty     (empty),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Data memory the DUT talks to (16 words, addresses kept small).
  logic [31:0] dmem [16] = '{default: 32'h0};
  assign mem_rdata = dmem[mem_addr[3:0]];
  always @(posedge clk) if (mem_write) dmem[mem_addr[3:0]] <= mem_wdata;

  // ---------------- reference model ----------------
  sb_entry_t   pend_q[$];
  logic [31:0] ref_mem [16] = '{default: 32'h0};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- driver: one CPU cycle, checked against the model ----------------
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic f);
    bit          is_load, match, drn;
    logic [31:0] fwd_data;
    cpu_read  = r;
    cpu_write = w;
    cpu_addr  = a;
    cpu_wdata = d;
    flush     = f;
    @(negedge clk);
    is_load  = r && !w;
    match    = 1'b0;
    fwd_data = '0;
    foreach (pend_q[i]) begin
      if (pend_q[i].addr == a) begin
        match    = 1'b1;
        fwd_data = pend_q[i].data;   // later entries are younger
      end
    end
    drn = (pend_q.size() != 0) &&
          (pend_q.size() == DEPTH || f || (!r && !w) || (!FWD && is_load && match));
    check("empty",     32'(empty),     32'(pend_q.size() == 0));
    check("stall",     32'(stall),     32'(is_load && drn));
    check("mem_write", 32'(mem_write), 32'(drn));
    check("mem_read",  32'(mem_read),  32'(is_load && !drn));
    if (drn) begin
      check("drain_addr", mem_addr,  pend_q[0].addr);
      check("drain_data", mem_wdata, pend_q[0].data);
      ref_mem[pend_q[0].addr[3:0]] = pend_q[0].data;
      void'(pend_q.pop_front());
    end else if (is_load) begin
      check("load_addr", mem_addr, a);
      check("load_data", cpu_rdata, (FWD && match) ? fwd_data : ref_mem[a[3:0]]);
    end
    if (w) pend_q.push_back('{addr: a, data: d});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; flush = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_read",  32'(mem_read),  32'd0);
    check("rst_stall",     32'(stall),     32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back stores to 5,6,7 then idle: three consecutive drains in order.
    step(1'b0, 1'b1, 32'd5, 32'h0000_0505, 1'b0);
    step(1'b0, 1'b1, 32'd6, 32'h0000_0606, 1'b0);
    step(1'b0, 1'b1, 32'd7, 32'h0000_0707, 1'b0);
    idle(4);

    // Fill, store while full, then a load forced to wait one drain.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'(10 + i), $urandom, 1'b0);
    step(1'b0, 1'b1, 32'd9, 32'h0000_0909, 1'b0);
    step(1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
    idle(5);

    // Two stores to the same address then loads of it.
    step(1'b0, 1'b1, 32'd3, 32'h0000_AAAA, 1'b0);
    step(1'b0, 1'b1, 32'd3, 32'h0000_BBBB, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd3, 32'h0, 1'b0);
    check("final_load_3", cpu_rdata, 32'h0000_BBBB);
    idle(3);

    // Flush with loads to a non-matching address.
    step(1'b0, 1'b1, 32'd1, 32'h0000_1111, 1'b0);
    step(1'b0, 1'b1, 32'd2, 32'h0000_2222, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd8, 32'h0, 1'b1);
    idle(1);

    // Reset asserted mid-drain with three entries pending.
    step(1'b0, 1'b1, 32'd12, 32'hDEAD_0001, 1'b0);
    step(1'b0, 1'b1, 32'd13, 32'hDEAD_0002, 1'b0);
    step(1'b0, 1'b1, 32'd14, 32'hDEAD_0003, 1'b0);
    cpu_read = 1'b0; cpu_write = 1'b0; flush = 1'b0;
    #2;
    check("pre_reset_drain", 32'(mem_write), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_empty",     32'(empty),     32'd1);
    check("midrst_mem_write", 32'(mem_write), 32'd0);
    check("midrst_stall",     32'(stall),     32'd0);
    pend_q.delete();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    idle(4);

    // Randomized traffic, including the illegal read+write combination.
    for (int i = 0; i < 400; i++) begin
      logic r, w, f;
      r = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 7) == 0);
      step(r, w, 32'($urandom_range(0, 7)), $urandom, f);
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Memory image must equal the model once everything has drained.
    for (int i = 0; i < 16; i++) check($sformatf("mem_img_%0d", i), dmem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
